// File: rtl/seq_addsub_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_addsub_alu_if
//  Description : Request/response bundle for the sequential adder/subtractor.
//                The master (execute stage) issues start/op/operands and the
//                slave (ALU) returns the handshake and the result with flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_addsub_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, sum, carry, overflow, zero, negative
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, sum, carry, overflow, zero, negative
    );
endinterface
`default_nettype wire

// File: rtl/seq_addsub_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_addsub_alu
//  Description : Multi-cycle two's complement adder/subtractor. Operands are
//                consumed DIGIT bits per clock, LSB chunk first, through a
//                DIGIT-wide ripple slice with a registered inter-chunk carry.
//                Supports ADD/SUB/ADC/SBC with carry, overflow, zero and
//                negative flags and a start/busy/done handshake.
//                Optional macro SEQ_ADDSUB_SATURATE_EN clamps the result to
//                the signed extreme on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_addsub_alu #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_addsub_alu_if.slave bus
);

    localparam int c_chunks = WIDTH / DIGIT;
    localparam int c_cnt_w  = (c_chunks > 1) ? $clog2(c_chunks) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_chunks - 1);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [0:0]         state_q,    state_d;
    logic [c_cnt_w-1:0] cnt_q,      cnt_d;
    // Operands shift right one chunk per cycle, so the active chunk always
    // sits in the low DIGIT bits; on the final chunk those bits hold the
    // original MSBs needed for the overflow rule.
    logic [WIDTH-1:0]   a_q,        a_d;
    logic [WIDTH-1:0]   b_q,        b_d;
    logic               cy_q,       cy_d;
    logic [WIDTH-1:0]   sum_q,      sum_d;
    logic               carry_q,    carry_d;
    logic               ovf_q,      ovf_d;
    logic               zero_q,     zero_d;
    logic               neg_q,      neg_d;
    logic               done_q,     done_d;

    logic               w_last;
    logic [DIGIT:0]     w_chunk;
    logic [WIDTH-1:0]   w_raw_sum;
    logic [WIDTH-1:0]   w_final_sum;
    logic               w_ovf;

    // Ripple slice for the current chunk with the registered carry.
    assign w_chunk = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, cy_q};

    assign w_last = (cnt_q == c_last);

    // Progressive result: only the chunk addressed by the counter changes.
    for (genvar g = 0; g < c_chunks; g++) begin : g_chunk
        assign w_raw_sum[g*DIGIT +: DIGIT] = (cnt_q == c_cnt_w'(g))
                                           ? w_chunk[DIGIT-1:0]
                                           : sum_q[g*DIGIT +: DIGIT];
    end

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign w_ovf = (a_q[DIGIT-1] == b_q[DIGIT-1]) &&
                   (w_raw_sum[WIDTH-1] != a_q[DIGIT-1]);

`ifdef SEQ_ADDSUB_SATURATE_EN
    // Clamp toward the sign of A, which is the sign the true result carries.
    assign w_final_sum = !w_ovf        ? w_raw_sum :
                         a_q[DIGIT-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                         {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_final_sum = w_raw_sum;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:  if (bus.start) state_d = c_run;
            c_run:   if (w_last)    state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    // Datapath next values: operand capture on start, chunk steps in RUN.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        case (state_q)
            c_idle: begin
                if (bus.start) begin
                    cnt_d = '0;
                    a_d   = bus.a;
                    // op[0] selects subtraction (invert B), op[1] selects
                    // the external carry-in instead of the implicit one.
                    b_d   = bus.op[0] ? ~bus.b : bus.b;
                    cy_d  = bus.op[1] ? bus.cin : bus.op[0];
                end
            end
            c_run: begin
                cnt_d = cnt_q + c_cnt_w'(1);
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cy_d  = w_chunk[DIGIT];
                sum_d = w_raw_sum;
                if (w_last) begin
                    sum_d   = w_final_sum;
                    carry_d = w_chunk[DIGIT];
                    ovf_d   = w_ovf;
                    zero_d  = (w_final_sum == '0);
                    neg_d   = w_final_sum[WIDTH-1];
                    done_d  = 1'b1;
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset clears operands, result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
        end
    end

    // Output drive: busy decoded from state, everything else registered.
    always_comb begin
        bus.busy     = (state_q == c_run);
        bus.done     = done_q;
        bus.sum      = sum_q;
        bus.carry    = carry_q;
        bus.overflow = ovf_q;
        bus.zero     = zero_q;
        bus.negative = neg_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_addsub_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seq_addsub_alu
//  Description : Self-checking bench for seq_addsub_alu (WIDTH=8, DIGIT=2):
//                directed vector table, handshake corner sequences and
//                random operations against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_addsub_alu;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int c_lat = WIDTH / DIGIT;

    localparam logic [1:0] c_add = 2'b00;
    localparam logic [1:0] c_sub = 2'b01;
    localparam logic [1:0] c_adc = 2'b10;
    localparam logic [1:0] c_sbc = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    seq_addsub_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_addsub_alu #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } vec_t;

    localparam int c_nvec = 10;
    vec_t vt [c_nvec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {carry, overflow, zero, negative, sum}
    function automatic logic [11:0] dut_res();
        return {bus.carry, bus.overflow, bus.zero, bus.negative, bus.sum};
    endfunction

    // Reference model from plain integer arithmetic.
    function automatic logic [11:0] model(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
        int   ai, bi, c0, full, sa, sb, s, res;
        logic c, v;
        ai   = int'(a);
        bi   = op[0] ? (255 - int'(b)) : int'(b);
        c0   = op[1] ? int'(cin) : int'(op[0]);
        full = ai + bi + c0;
        res  = full % 256;
        c    = (full >= 256);
        sa   = (ai >= 128) ? ai - 256 : ai;
        sb   = (bi >= 128) ? bi - 256 : bi;
        s    = sa + sb + c0;
        v    = (s > 127) || (s < -128);
`ifdef SEQ_ADDSUB_SATURATE_EN
        if (v) res = (ai >= 128) ? 128 : 127;
`endif
        return {c, v, (res == 0), (res >= 128), 8'(res)};
    endfunction

    // Present a request off-edge; it is sampled at the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Counts rising edges after the sampling edge until done is seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.busy) bcnt++;
            @(posedge clk);
            lat++;
        end
        if (lat >= 20) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic [11:0] exp);
        int lat, bcnt;
        issue(op, a, b, cin);
        wait_done(lat, bcnt);
        check({name, "_latency"}, 32'(lat), 32'(c_lat));
        check({name, "_busycycles"}, 32'(bcnt), 32'(c_lat));
        check({name, "_busy_at_done"}, 32'(bus.busy), 32'(0));
        check({name, "_result"}, 32'(dut_res()), 32'(exp));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int   lat, bcnt, cyc, seen;
        logic [1:0] rop;
        logic [7:0] ra, rb;
        logic       rc;

        vt[0] = '{c_add, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SEQ_ADDSUB_SATURATE_EN
        vt[1] = '{c_add, 8'h7F, 8'h1F, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{c_add, 8'h81, 8'h81, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[8] = '{c_sub, 8'h00, 8'h80, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        vt[1] = '{c_add, 8'h7F, 8'h1F, 1'b0, 8'h9E, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[2] = '{c_add, 8'h81, 8'h81, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8] = '{c_sub, 8'h00, 8'h80, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        vt[3] = '{c_sub, 8'h19, 8'hB1, 1'b0, 8'h68, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{c_sub, 8'h3D, 8'h3D, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[5] = '{c_adc, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[6] = '{c_sbc, 8'h10, 8'h01, 1'b0, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[7] = '{c_add, 8'h05, 8'h03, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9] = '{c_sub, 8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'({bus.busy, bus.done, dut_res()}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'({bus.busy, bus.done}), 32'(0));

        // Directed table; each request is presented in the previous done cycle.
        for (int i = 0; i < c_nvec; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].cin,
                   {vt[i].c, vt[i].v, vt[i].z, vt[i].n, vt[i].sum});
        end

        // Back-to-back: second start in the done cycle of the first.
        run_op("b2b_first", c_sub, 8'h19, 8'hB1, 1'b0, {4'b0000, 8'h68});
        issue(c_sub, 8'h3D, 8'h3D, 1'b0);
        @(negedge clk);
        check("b2b_done_drops", 32'(bus.done), 32'(0));
        check("b2b_accepted_busy", 32'(bus.busy), 32'(1));
        check("b2b_flags_hold", 32'({bus.carry, bus.overflow, bus.zero, bus.negative}), 32'(0));
        @(posedge clk);
        wait_done(lat, bcnt);
        check("b2b_second_latency", 32'(lat + 1), 32'(c_lat));
        check("b2b_second_result", 32'(dut_res()), 32'({4'b1010, 8'h00}));

        // Start pulse while busy is ignored.
        issue(c_add, 8'h01, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc  = 0;
        seen = 0;
        while (cyc < 10 && seen == 0) begin
            @(negedge clk);
            cyc++;
            if (bus.done) seen = 1;
        end
        check("ignored_start_latency", 32'(cyc), 32'(3));
        check("ignored_start_result", 32'(dut_res()), 32'({4'b0000, 8'h02}));
        @(negedge clk);
        check("ignored_start_no_rerun", 32'({bus.busy, bus.done}), 32'(0));

        // Reset mid-run aborts immediately with no later done.
        issue(c_add, 8'h7F, 8'h1F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy_before_reset", 32'(bus.busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", 32'({bus.busy, bus.done, dut_res()}), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("no_done_after_abort", 32'(seen), 32'(0));
        check("outputs_zero_after_abort", 32'(dut_res()), 32'(0));
        run_op("after_abort", c_add, 8'h05, 8'h03, 1'b0, model(c_add, 8'h05, 8'h03, 1'b0));

        // Random operations against the reference model.
        for (int r = 0; r < 150; r++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            issue(rop, ra, rb, rc);
            wait_done(lat, bcnt);
            check($sformatf("rand%0d_op%0d_%02h_%02h_%0d_latency", r, rop, ra, rb, rc),
                  32'(lat), 32'(c_lat));
            check($sformatf("rand%0d_op%0d_%02h_%02h_%0d_result", r, rop, ra, rb, rc),
                  32'(dut_res()), 32'(model(rop, ra, rb, rc)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
